i2c_interval_checker: RTL and testbench
=======================================

Name: i2c_interval_checker

Overview:
- Synchronous interval checker for I2C bus timing verification: tCHD;STA, tLOW, tHD;DAT, tSU;DAT, tHIGH, tSU;STA, tSU;STO.
- Measures the clk cycles from a qualifying event on s1 to the next qualifying event on s2.
- Flags a violation when that interval is shorter than the limit `lim`.
- One instance per timing rule. Instances sit beside the I2C master and observe the bus lines; edge-type parameters select the EE, EL or LE variant.

Parameters:
- S1_ANY, default 0: s1 event type. 0 = rising edge only; 1 = any change.
- S2_ANY, default 0: s2 event type. 0 = rising edge only; 1 = any change.
- CNT_W, default 64: width of the interval counter, `lim` and `delta`.
- VIO_LEN, default 2: number of clk cycles `vio` stays high after a violation.
- ERR_W, default 16: width of the violation counter.

Ports:
- clk, input, 1: sampling clock. Also the unit of all intervals.
- rst, input, 1: reset; asynchronous, active-high.
- s1, input, 1: reference signal; its event starts the interval.
- s2, input, 1: checked signal; its event ends the interval.
- lim, input, CNT_W: minimum legal interval in clk cycles. Treated as static; sampled each cycle.
- vio, output, 1: violation flag, stretched to VIO_LEN cycles.
- delta, output, CNT_W: measured interval of the most recent violation.
- err_cnt, output, ERR_W: saturating count of violations since reset.

Behaviour:
- Reset values: vio=0, delta=0, err_cnt=0, cnt=all-ones (saturated, "no s1 seen"), armed=0, s1_q=0, s2_q=0, vio_tmr=0.
- Sampling:
  - s1_q and s2_q register s1 and s2 every cycle.
  - armed is set on the first clk after rst deasserts.
  - No events are detected while armed=0; that cycle only loads s1_q and s2_q.
- Events (armed=1):
  - s1_evt = S1_ANY ? (s1 != s1_q) : (s1 & ~s1_q).
  - s2_evt follows the same rule using S2_ANY.
- Counter:
  - If s1_evt, cnt <= 1.
  - Otherwise, if cnt != all-ones, cnt <= cnt + 1.
  - Result: in the cycle of an s2_evt, cnt equals the cycles elapsed since the last s1_evt. It saturates at all-ones.
- Check: in a cycle with s2_evt and cnt < lim:
  - delta <= cnt.
  - err_cnt increments, saturating at all-ones.
  - vio_tmr <= VIO_LEN.
- vio = (vio_tmr != 0). vio_tmr decrements each cycle while nonzero.
  - A new violation while vio is high reloads the timer; no pulse is lost, the flag is extended.
- Simultaneous s1_evt and s2_evt: the check uses the old cnt, i.e. the interval from the previous s1 event. cnt then restarts at 1.
- No s1 event since reset: cnt is all-ones and can never be < lim, so no violation is possible.
- lim=0: the checker can never fire.
- Reset mid-operation clears everything and disarms; the first post-reset cycle is a sampling-only cycle.
- Variants:
  - EE: S1_ANY=0, S2_ANY=0.
  - EL: S1_ANY=0, S2_ANY=1.
  - LE: S1_ANY=1, S2_ANY=0.
- Simulation only: on each violation, print the delta and cycle count with $display, inside translate_off.

Decomposition:
- Shared package i2c_timing_pkg:
  - Event-type constants EVT_RISE=0 and EVT_ANY=1.
  - Default limits: PER_HI=40, PER_LO=47, PER_SU_DATA=3, PER_SU_RSRT=47, PER_HD_STRT=40, PER_HD_DATA=0, PER_SU_STOP=40, PER_TBUF=47.
- One natural sub-module, sig_event_det: registered edge detector with parameter ANY, inputs clk/rst/en/d, output evt. Instantiated twice.

Test Plan:
- EE, lim=40: s1 rises at cycle 10, s2 rises at cycle 30 -> vio high at cycles 31-32, delta=20, err_cnt=1.
- EE, lim=40: s1 rises at cycle 10, s2 rises at cycle 50 (interval 40) -> no vio, err_cnt=0. Boundary: equal to lim is legal.
- EL, lim=3: s1 rises at cycle 5, s2 falls at cycle 7 -> vio, delta=2. With S2_ANY=0 the same falling stimulus gives no vio.
- LE, lim=47:
  - s1 falls at cycle 100, s2 rises at cycle 120 -> vio, delta=20.
  - s1 falls again at cycle 200, s2 rises at cycle 260 -> no new violation.
- Simultaneous: s1 rises at cycle 10; s1 and s2 both rise at cycle 60 with lim=40 -> no vio (interval 50). A later s2 rise at cycle 70 -> vio, delta=10.
- Reset/arming and VIO_LEN=2:
  - s2 rising edges before any s1 event -> no vio.
  - Assert rst during an active vio -> vio=0 and err_cnt=0 immediately.
  - Two violations 1 cycle apart -> vio stays high continuously for 3 cycles and err_cnt=2.

Source files
------------

// File: rtl/i2c_timing_pkg.sv
// Shared I2C timing constants: event types and default
// interval limits in clk cycles.
package i2c_timing_pkg;

  localparam bit EVT_RISE = 1'b0;
  localparam bit EVT_ANY  = 1'b1;

  localparam int unsigned PER_HI      = 40;
  localparam int unsigned PER_LO      = 47;
  localparam int unsigned PER_SU_DATA = 3;
  localparam int unsigned PER_SU_RSRT = 47;
  localparam int unsigned PER_HD_STRT = 40;
  localparam int unsigned PER_HD_DATA = 0;
  localparam int unsigned PER_SU_STOP = 40;
  localparam int unsigned PER_TBUF    = 47;

endpackage

// File: rtl/i2c_interval_checker_evt.sv
// Registered edge detector: rising edge or any change,
// gated by en so unarmed cycles only load the history.
module sig_event_det
  import i2c_timing_pkg::*;
#(
  parameter bit ANY = EVT_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic evt
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  always_comb begin
    evt = 1'b0;
    if (en) evt = ANY ? (d ^ d_q) : (d & ~d_q);
  end

endmodule

// File: rtl/i2c_interval_checker.sv
// Minimum-interval checker between an s1 event and the
// following s2 event; flags, records and counts violations.
module i2c_interval_checker
  import i2c_timing_pkg::*;
#(
  parameter bit          S1_ANY  = EVT_RISE,
  parameter bit          S2_ANY  = EVT_RISE,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned VIO_LEN = 2,
  parameter int unsigned ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1,
  input  logic             s2,
  input  logic [CNT_W-1:0] lim,
  output logic             vio,
  output logic [CNT_W-1:0] delta,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int TMR_W =
    (VIO_LEN < 2) ? 1 : $clog2(VIO_LEN + 1);

  logic             armed;
  logic             s1_evt;
  logic             s2_evt;
  logic             hit;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] vio_tmr;

  sig_event_det #(.ANY(S1_ANY)) u_s1 (
    .clk (clk),
    .rst (rst),
    .en  (armed),
    .d   (s1),
    .evt (s1_evt)
  );

  sig_event_det #(.ANY(S2_ANY)) u_s2 (
    .clk (clk),
    .rst (rst),
    .en  (armed),
    .d   (s2),
    .evt (s2_evt)
  );

  // cnt is the pre-update value, so a coincident s1 event
  // is checked against the previous s1 reference
  assign hit = s2_evt && (cnt < lim);
  assign vio = (vio_tmr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '1;
    else if (s1_evt)      cnt <= CNT_W'(1);
    else if (cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delta   <= '0;
      err_cnt <= '0;
    end else if (hit) begin
      delta <= cnt;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 vio_tmr <= '0;
    else if (hit)            vio_tmr <= TMR_W'(VIO_LEN);
    else if (vio_tmr != '0)  vio_tmr <= vio_tmr - TMR_W'(1);
  end

`ifndef SYNTHESIS
  logic [63:0] cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst && hit)
      $display("i2c_interval_checker: violation delta=%0d cycle=%0d",
               cnt, cyc);
  end
`endif

endmodule

// File: tb/tb_i2c_interval_checker.sv
// Directed bench for i2c_interval_checker: EE, EL and LE
// variants driven from shared s1/s2/lim stimulus.
module tb_i2c_interval_checker;
  import i2c_timing_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s1  = 1'b0;
  logic        s2  = 1'b0;
  logic [63:0] lim = 64'd0;

  logic        vio_ee, vio_el, vio_le;
  logic [63:0] delta_ee, delta_el, delta_le;
  logic [15:0] err_ee, err_el, err_le;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_interval_checker #(.S1_ANY(EVT_RISE), .S2_ANY(EVT_RISE)) u_ee (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim),
    .vio(vio_ee), .delta(delta_ee), .err_cnt(err_ee)
  );

  i2c_interval_checker #(.S1_ANY(EVT_RISE), .S2_ANY(EVT_ANY)) u_el (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim),
    .vio(vio_el), .delta(delta_el), .err_cnt(err_el)
  );

  i2c_interval_checker #(.S1_ANY(EVT_ANY), .S2_ANY(EVT_RISE)) u_le (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim),
    .vio(vio_le), .delta(delta_le), .err_cnt(err_le)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // reset, then one sampling-only arming edge
  task automatic do_reset(input logic a, input logic b);
    rst = 1'b1;
    s1  = a;
    s2  = b;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s1  = 1'b0;
    s2  = 1'b0;
    lim = 64'(PER_HI);
    #1;
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vio got %0b want 0", vio_ee);
    end
    n_run++;
    if (delta_le !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_delta got %0d want 0", delta_le);
    end
    n_run++;
    if (err_el !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err got %0d want 0", err_el);
    end
    tick();
  endtask

  task automatic test_ee_short();
    do_reset(1'b0, 1'b0);
    lim = 64'(PER_HI);
    idle(9);
    s1 = 1'b1;
    tick();
    idle(19);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b1) begin
      n_fail++;
      $display("FAIL ee_vio1 got %0b want 1", vio_ee);
    end
    n_run++;
    if (delta_ee !== 64'd20) begin
      n_fail++;
      $display("FAIL ee_delta got %0d want 20", delta_ee);
    end
    n_run++;
    if (err_ee !== 16'd1) begin
      n_fail++;
      $display("FAIL ee_err got %0d want 1", err_ee);
    end
    tick();
    n_run++;
    if (vio_ee !== 1'b1) begin
      n_fail++;
      $display("FAIL ee_vio2 got %0b want 1", vio_ee);
    end
    tick();
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL ee_vio_end got %0b want 0", vio_ee);
    end
  endtask

  task automatic test_ee_equal();
    do_reset(1'b0, 1'b0);
    lim = 64'(PER_HI);
    idle(9);
    s1 = 1'b1;
    tick();
    idle(39);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_vio got %0b want 0", vio_ee);
    end
    idle(2);
    n_run++;
    if (err_ee !== 16'd0) begin
      n_fail++;
      $display("FAIL eq_err got %0d want 0", err_ee);
    end
  endtask

  task automatic test_el();
    do_reset(1'b0, 1'b1);
    lim = 64'(PER_SU_DATA);
    idle(4);
    s1 = 1'b1;
    tick();
    tick();
    s2 = 1'b0;
    tick();
    n_run++;
    if (vio_el !== 1'b1) begin
      n_fail++;
      $display("FAIL el_vio got %0b want 1", vio_el);
    end
    n_run++;
    if (delta_el !== 64'd2) begin
      n_fail++;
      $display("FAIL el_delta got %0d want 2", delta_el);
    end
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL el_ee_vio got %0b want 0", vio_ee);
    end
    n_run++;
    if (err_ee !== 16'd0) begin
      n_fail++;
      $display("FAIL el_ee_err got %0d want 0", err_ee);
    end
  endtask

  task automatic test_le();
    do_reset(1'b1, 1'b0);
    lim = 64'(PER_LO);
    idle(20);
    s1 = 1'b0;
    tick();
    idle(19);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_le !== 1'b1) begin
      n_fail++;
      $display("FAIL le_vio got %0b want 1", vio_le);
    end
    n_run++;
    if (delta_le !== 64'd20) begin
      n_fail++;
      $display("FAIL le_delta got %0d want 20", delta_le);
    end
    tick();
    s2 = 1'b0;
    tick();
    idle(20);
    s1 = 1'b1;
    tick();
    idle(29);
    s1 = 1'b0;
    tick();
    idle(59);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_le !== 1'b0) begin
      n_fail++;
      $display("FAIL le_vio_late got %0b want 0", vio_le);
    end
    n_run++;
    if (err_le !== 16'd1) begin
      n_fail++;
      $display("FAIL le_err got %0d want 1", err_le);
    end
    n_run++;
    if (delta_le !== 64'd20) begin
      n_fail++;
      $display("FAIL le_delta_hold got %0d want 20", delta_le);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, 1'b0);
    lim = 64'(PER_HI);
    idle(9);
    s1 = 1'b1;
    tick();
    idle(19);
    s1 = 1'b0;
    tick();
    idle(29);
    s1 = 1'b1;
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_vio got %0b want 0", vio_ee);
    end
    idle(4);
    s2 = 1'b0;
    tick();
    idle(4);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_vio_late got %0b want 1", vio_ee);
    end
    n_run++;
    if (delta_ee !== 64'd10) begin
      n_fail++;
      $display("FAIL sim_delta got %0d want 10", delta_ee);
    end
  endtask

  task automatic test_lim_zero();
    do_reset(1'b0, 1'b0);
    lim = 64'd0;
    s1 = 1'b1;
    tick();
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL lim0_vio got %0b want 0", vio_ee);
    end
    n_run++;
    if (err_ee !== 16'd0) begin
      n_fail++;
      $display("FAIL lim0_err got %0d want 0", err_ee);
    end
  endtask

  task automatic test_arming_reset();
    do_reset(1'b0, 1'b0);
    lim = 64'(PER_HI);
    repeat (3) begin
      s2 = 1'b1;
      tick();
      s2 = 1'b0;
      tick();
    end
    n_run++;
    if (err_ee !== 16'd0) begin
      n_fail++;
      $display("FAIL nos1_err got %0d want 0", err_ee);
    end
    s1 = 1'b1;
    tick();
    idle(4);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_ee !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_vio got %0b want 1", vio_ee);
    end
    rst = 1'b1;
    #1;
    n_run++;
    if (vio_ee !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vio got %0b want 0", vio_ee);
    end
    n_run++;
    if (err_ee !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_err got %0d want 0", err_ee);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0, 1'b0);
    lim = 64'(PER_HI);
    s1 = 1'b1;
    tick();
    idle(2);
    s2 = 1'b1;
    tick();
    n_run++;
    if (vio_el !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_vio1 got %0b want 1", vio_el);
    end
    s2 = 1'b0;
    tick();
    n_run++;
    if (vio_el !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_vio2 got %0b want 1", vio_el);
    end
    n_run++;
    if (delta_el !== 64'd4) begin
      n_fail++;
      $display("FAIL b2b_delta got %0d want 4", delta_el);
    end
    tick();
    n_run++;
    if (vio_el !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_vio3 got %0b want 1", vio_el);
    end
    tick();
    n_run++;
    if (vio_el !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_vio_end got %0b want 0", vio_el);
    end
    n_run++;
    if (err_el !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_err got %0d want 2", err_el);
    end
  endtask

  initial begin
    test_reset();
    test_ee_short();
    test_ee_equal();
    test_el();
    test_le();
    test_simultaneous();
    test_lim_zero();
    test_arming_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
